// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with hysteresis flow control.
// A lane producer writes through push/valid/data_in. The downstream arbiter
// reads with pop and receives pause/continua back-pressure.
// Ports:
//   clk, reset (async, active-low)
//   push, valid, data_in       write side
//   pop, data_out, valid_out   read side (1-cycle read latency)
//   umbral_alto, umbral_bajo   pause / resume thresholds (alto == 0 disables)
//   empty, full, count         occupancy
//   pause, continua            flow-control level / resume pulse
//   overflow_err, underflow_err  sticky error flags
module fifo_flow_ctrl #(
    parameter int unsigned BUS_SIZE   = 5,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  valid,
    input  logic [BUS_SIZE-1:0]   data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [BUS_SIZE-1:0]   data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  pause,
    output logic                  continua,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int unsigned MEM_LENGTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_PAUSED = 1'b1
    } fc_state_e;

    logic [BUS_SIZE-1:0]   mem_q [MEM_LENGTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [BUS_SIZE-1:0]   data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    fc_state_e             state_q, state_d;
    logic                  pause_q, pause_d;
    logic                  continua_q, continua_d;

    logic empty_c, full_c, rd_acc_c, wr_acc_c;

    // Occupancy flags come straight from the registered count.
    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(MEM_LENGTH));

    // A pop on a full FIFO frees a slot in the same cycle, so the push is kept.
    assign rd_acc_c = pop & ~empty_c;
    assign wr_acc_c = push & valid & (~full_c | rd_acc_c);

    // Datapath next-state: pointers, count, read data, sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end
        if (push && valid && !wr_acc_c) begin
            ovf_d = 1'b1;
        end
        if (pop && empty_c) begin
            unf_d = 1'b1;
        end
    end

    // Flow-control FSM next-state and registered outputs.
    always_comb begin
        state_d    = state_q;
        pause_d    = 1'b0;
        continua_d = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if ((umbral_alto != '0) && (count_q >= umbral_alto)) begin
                    state_d = ST_PAUSED;
                    pause_d = 1'b1;
                end
            end
            ST_PAUSED: begin
                pause_d = 1'b1;
                // Disabling flow control also releases the producer.
                if ((umbral_alto == '0) || (count_q <= umbral_bajo)) begin
                    state_d    = ST_NORMAL;
                    pause_d    = 1'b0;
                    continua_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            state_q     <= ST_NORMAL;
            pause_q     <= 1'b0;
            continua_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            state_q     <= state_d;
            pause_q     <= pause_d;
            continua_q  <= continua_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign empty         = empty_c;
    assign full          = full_c;
    assign count         = count_q;
    assign pause         = pause_q;
    assign continua      = continua_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl (BUS_SIZE=5, ADDR_WIDTH=3, thresholds 6/2).
module tb_fifo_flow_ctrl;

    logic       clk;
    logic       reset;
    logic       push;
    logic       valid;
    logic [4:0] data_in;
    logic       pop;
    logic [3:0] umbral_alto;
    logic [3:0] umbral_bajo;
    logic [4:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       pause;
    logic       continua;
    logic       overflow_err;
    logic       underflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] model[$];
    logic [4:0] exp_d;

    fifo_flow_ctrl #(.BUS_SIZE(5), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .valid        (valid),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .pause        (pause),
        .continua     (continua),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".count"},    32'(count), 0);
        check_eq({tag, ".empty"},    32'(empty), 1);
        check_eq({tag, ".full"},     32'(full), 0);
        check_eq({tag, ".dout"},     32'(data_out), 0);
        check_eq({tag, ".vout"},     32'(valid_out), 0);
        check_eq({tag, ".pause"},    32'(pause), 0);
        check_eq({tag, ".continua"}, 32'(continua), 0);
        check_eq({tag, ".ovf"},      32'(overflow_err), 0);
        check_eq({tag, ".unf"},      32'(underflow_err), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        push        = 1'b0;
        valid       = 1'b0;
        data_in     = '0;
        pop         = 1'b0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        tick();
        tick();
        check_reset_state("rst0");
        reset = 1'b1;

        // Fill 1..8; pause follows count>=6 by one cycle.
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; valid = 1'b1; data_in = 5'(i);
            tick();
            check_eq($sformatf("fill%0d.count", i), 32'(count), 32'(i));
            check_eq($sformatf("fill%0d.pause", i), 32'(pause), 32'(i >= 7));
            check_eq($sformatf("fill%0d.full", i),  32'(full),  32'(i == 8));
        end
        // Ninth push is dropped.
        data_in = 5'd9;
        tick();
        check_eq("ovf.count", 32'(count), 8);
        check_eq("ovf.flag",  32'(overflow_err), 1);
        check_eq("ovf.unf",   32'(underflow_err), 0);
        push = 1'b0; valid = 1'b0;

        // Drain: continua pulses once after count reaches 2.
        pop = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq($sformatf("drain%0d.dout", k),  32'(data_out), 32'(k));
            check_eq($sformatf("drain%0d.vout", k),  32'(valid_out), 1);
            check_eq($sformatf("drain%0d.count", k), 32'(count), 32'(8 - k));
            check_eq($sformatf("drain%0d.cont", k),  32'(continua), 32'(k == 7));
            check_eq($sformatf("drain%0d.pause", k), 32'(pause), 32'(k < 7));
        end
        check_eq("drain.empty", 32'(empty), 1);

        // Pop on empty.
        tick();
        check_eq("unf.flag",  32'(underflow_err), 1);
        check_eq("unf.vout",  32'(valid_out), 0);
        check_eq("unf.count", 32'(count), 0);
        check_eq("unf.dout",  32'(data_out), 8);
        pop = 1'b0;

        // Push without valid is ignored.
        push = 1'b1; valid = 1'b0; data_in = 5'd17;
        tick();
        check_eq("novalid.count", 32'(count), 0);
        push = 1'b0;

        // Fresh start, preload 3 then stream 20 push+pop cycles across pointer wraps.
        do_reset();
        model.delete();
        for (int i = 1; i <= 3; i++) begin
            push = 1'b1; valid = 1'b1; data_in = 5'(i);
            model.push_back(5'(i));
            tick();
        end
        check_eq("pre.count", 32'(count), 3);
        pop = 1'b1;
        for (int j = 0; j < 20; j++) begin
            data_in = 5'(10 + j);
            exp_d = model.pop_front();
            model.push_back(5'(10 + j));
            tick();
            check_eq($sformatf("stream%0d.dout", j),  32'(data_out), 32'(exp_d));
            check_eq($sformatf("stream%0d.count", j), 32'(count), 3);
            check_eq($sformatf("stream%0d.pause", j), 32'(pause), 0);
        end
        check_eq("stream.ovf", 32'(overflow_err), 0);
        check_eq("stream.unf", 32'(underflow_err), 0);
        check_eq("stream.cont", 32'(continua), 0);

        // Fill to 8 then push+pop on full.
        pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = 5'(20 + i);
            model.push_back(5'(20 + i));
            tick();
        end
        check_eq("fullpp.pre_full", 32'(full), 1);
        pop = 1'b1; data_in = 5'd30;
        exp_d = model.pop_front();
        model.push_back(5'd30);
        tick();
        check_eq("fullpp.dout",  32'(data_out), 32'(exp_d));
        check_eq("fullpp.count", 32'(count), 8);
        check_eq("fullpp.ovf",   32'(overflow_err), 0);
        push = 1'b0; valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_d = model.pop_front();
            tick();
            check_eq($sformatf("fulldrain%0d.dout", k), 32'(data_out), 32'(exp_d));
        end
        check_eq("fulldrain.last", 32'(data_out), 30);
        check_eq("fulldrain.empty", 32'(empty), 1);

        // Set an error, start a burst, then assert reset between edges.
        tick();
        check_eq("preburst.unf", 32'(underflow_err), 1);
        pop = 1'b0;
        push = 1'b1; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 5'(11 + i);
            tick();
        end
        check_eq("preburst.count", 32'(count), 3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("asyncrst");
        push = 1'b0; valid = 1'b0;
        tick();
        check_eq("rsthold.count", 32'(count), 0);
        reset = 1'b1;

        // After release: push 5, pop, read 5 a cycle later.
        push = 1'b1; valid = 1'b1; data_in = 5'd5;
        tick();
        push = 1'b0; valid = 1'b0; pop = 1'b1;
        check_eq("post.count", 32'(count), 1);
        tick();
        pop = 1'b0;
        check_eq("post.dout", 32'(data_out), 5);
        check_eq("post.vout", 32'(valid_out), 1);
        check_eq("post.empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
